otter_mem_hs: RTL and testbench

- Parametrised next-generation OTTER unified memory: synchronous BRAM, instruction port plus data port with memory-mapped IO.
- Depth, MMIO base and init file are parameters. Data port adds a request/busy/done handshake, programmable wait states, and misalignment/out-of-range error reporting.
- Sits between the OTTER CPU (PC → port 1, load/store unit → port 2) and the IO bus.

---
 rtl/otter_mem_hs.sv | 168 ++++++++++++++++
 tb/tb_otter_mem_hs.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_mem_hs.sv
// OTTER unified memory: BRAM with an instruction read port and a handshaked data port
// (wait states, sized/extended loads, byte-lane stores, MMIO routing, error reporting).
module otter_mem_hs #(
  parameter int unsigned ADDR_WIDTH  = 14,
  parameter logic [31:0] MMIO_BASE   = 32'h0001_0000,
  parameter int unsigned WAIT_STATES = 0,
  parameter string       INIT_FILE   = "otter_memory.mem"
) (
  input  logic                  MEM_CLK,
  input  logic                  MEM_RST_N,
  input  logic                  MEM_RDEN1,
  input  logic [ADDR_WIDTH-1:0] MEM_ADDR1,
  output logic [31:0]           MEM_DOUT1,
  input  logic                  MEM_REQ2,
  input  logic                  MEM_WE2,
  input  logic [31:0]           MEM_ADDR2,
  input  logic [31:0]           MEM_DIN2,
  input  logic [1:0]            MEM_SIZE,
  input  logic                  MEM_SIGN,
  output logic                  MEM_BUSY2,
  output logic                  MEM_DONE2,
  output logic [31:0]           MEM_DOUT2,
  output logic                  MEM_ERR2,
  input  logic [31:0]           IO_IN,
  output logic                  IO_WR,
  output logic                  IO_RD,
  output logic [31:0]           IO_ADDR,
  output logic [31:0]           IO_DOUT
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StWait   = 2'd1;
  localparam logic [1:0] StAccess = 2'd2;
  localparam logic [1:0] StResp   = 2'd3;

  localparam int unsigned Depth    = 2 ** ADDR_WIDTH;
  localparam logic [32:0] MemBytes = 33'(Depth) << 2;
  localparam logic [3:0]  WaitLast = 4'(WAIT_STATES - 1);

  logic [31:0] mem_q [Depth];

  logic [1:0]  state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        we_q, we_d, sign_q, sign_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, din_q, din_d, rdata_q, rdata_d, dout2_q, dout2_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] dout1_q;

  logic                  accept, in_access, in_resp, is_io, access_err, mem_we;
  logic [1:0]            offset;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [3:0]            be;
  logic [31:0]           wdata, shifted, fmt;

  always_comb begin
    accept     = MEM_REQ2 && (state_q == StIdle || state_q == StResp);
    in_access  = state_q == StAccess;
    in_resp    = state_q == StResp;
    offset     = addr_q[1:0];
    word_idx   = addr_q[ADDR_WIDTH+1:2];
    is_io      = addr_q >= MMIO_BASE;
    access_err = (size_q == 2'd3) || (size_q == 2'd1 && offset == 2'd3) ||
                 (size_q == 2'd2 && offset != 2'd0) ||
                 (!is_io && ({1'b0, addr_q} >= MemBytes));
    mem_we     = in_access && !is_io && !access_err && we_q;
    IO_WR      = in_access && is_io && !access_err && we_q;
    IO_RD      = in_access && is_io && !access_err && !we_q;

    wdata = din_q << {offset, 3'b000};
    case (size_q)
      2'd0:    be = 4'b0001 << offset;
      2'd1:    be = 4'b0011 << offset;
      default: be = 4'b1111;
    endcase

    shifted = rdata_q >> {offset, 3'b000};
    case (size_q)
      2'd0:    fmt = sign_q ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'd1:    fmt = sign_q ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: fmt = rdata_q;
    endcase
    if (err_q) fmt = 32'd0;
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    din_d      = din_q;
    size_d     = size_q;
    sign_d     = sign_q;
    err_d      = in_access ? access_err : err_q;
    rdata_d    = rdata_q;
    dout2_d    = in_resp ? fmt : dout2_q;
    if (in_access) rdata_d = is_io ? IO_IN : mem_q[word_idx];

    case (state_q)
      StWait: begin
        if (wait_cnt_q == WaitLast) begin
          state_d    = StAccess;
          wait_cnt_d = 4'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      StAccess: state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // A request arriving in RESP is taken in the same cycle as the response.
    if (accept) begin
      state_d = (WAIT_STATES > 0) ? StWait : StAccess;
      we_d    = MEM_WE2;
      addr_d  = MEM_ADDR2;
      din_d   = MEM_DIN2;
      size_d  = MEM_SIZE;
      sign_d  = MEM_SIGN;
    end
  end

  always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
    if (!MEM_RST_N) begin
      state_q    <= StIdle;
      wait_cnt_q <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      din_q      <= 32'd0;
      size_q     <= 2'd0;
      sign_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 32'd0;
      dout2_q    <= 32'd0;
      dout1_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      size_q     <= size_d;
      sign_q     <= sign_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      dout2_q    <= dout2_d;
      if (MEM_RDEN1) dout1_q <= mem_q[MEM_ADDR1];
    end
  end

  // Memory is deliberately outside the reset domain; port 1 sees pre-write data.
  always_ff @(posedge MEM_CLK) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[word_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign MEM_DOUT1 = dout1_q;
  assign MEM_BUSY2 = state_q == StWait || state_q == StAccess;
  assign MEM_DONE2 = in_resp;
  assign MEM_ERR2  = in_resp && err_q;
  assign MEM_DOUT2 = in_resp ? fmt : dout2_q;
  assign IO_ADDR   = addr_q;
  assign IO_DOUT   = din_q;

endmodule

// File: tb/tb_otter_mem_hs.sv
// Bench for otter_mem_hs: one instance with no wait states, one with three, sharing inputs
// except the request strobes; results are compared against a byte-array reference model.
module tb_otter_mem_hs;

  localparam int unsigned AW   = 10;
  localparam int          WS3  = 3;
  localparam logic [31:0] MMIO = 32'h0001_0000;
  localparam logic [31:0] MEMB = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst_n, rden1, req0, req3, we2, sign2;
  logic [AW-1:0] addr1;
  logic [31:0]   addr2, din2, io_in;
  logic [1:0]    size2;

  logic [31:0] dout1_0, dout2_0, ioaddr_0, iodout_0;
  logic        busy_0, done_0, err_0, iowr_0, iord_0;
  logic [31:0] dout1_3, dout2_3, ioaddr_3, iodout_3;
  logic        busy_3, done_3, err_3, iowr_3, iord_3;

  int checks = 0;
  int failures = 0;
  logic [7:0] bmem [0:4095];

  always #5 clk = ~clk;

  otter_mem_hs #(.ADDR_WIDTH(AW), .MMIO_BASE(MMIO), .WAIT_STATES(0), .INIT_FILE("")) u_dut0 (
    .MEM_CLK(clk), .MEM_RST_N(rst_n), .MEM_RDEN1(rden1), .MEM_ADDR1(addr1),
    .MEM_DOUT1(dout1_0), .MEM_REQ2(req0), .MEM_WE2(we2), .MEM_ADDR2(addr2),
    .MEM_DIN2(din2), .MEM_SIZE(size2), .MEM_SIGN(sign2), .MEM_BUSY2(busy_0),
    .MEM_DONE2(done_0), .MEM_DOUT2(dout2_0), .MEM_ERR2(err_0), .IO_IN(io_in),
    .IO_WR(iowr_0), .IO_RD(iord_0), .IO_ADDR(ioaddr_0), .IO_DOUT(iodout_0)
  );

  otter_mem_hs #(.ADDR_WIDTH(AW), .MMIO_BASE(MMIO), .WAIT_STATES(WS3), .INIT_FILE("")) u_dut3 (
    .MEM_CLK(clk), .MEM_RST_N(rst_n), .MEM_RDEN1(rden1), .MEM_ADDR1(addr1),
    .MEM_DOUT1(dout1_3), .MEM_REQ2(req3), .MEM_WE2(we2), .MEM_ADDR2(addr2),
    .MEM_DIN2(din2), .MEM_SIZE(size2), .MEM_SIGN(sign2), .MEM_BUSY2(busy_3),
    .MEM_DONE2(done_3), .MEM_DOUT2(dout2_3), .MEM_ERR2(err_3), .IO_IN(io_in),
    .IO_WR(iowr_3), .IO_RD(iord_3), .IO_ADDR(ioaddr_3), .IO_DOUT(iodout_3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic exp_err(input logic [1:0] sz, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    if (sz == 2'd3) return 1'b1;
    if (off + nbytes(sz) > 4) return 1'b1;
    if (sz == 2'd2 && off != 0) return 1'b1;
    return (a < MMIO) && (a >= MEMB);
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic sg,
                                           input logic [31:0] a, input logic [31:0] ioval);
    logic [31:0] v;
    logic [7:0]  b;
    int n, k;
    n = nbytes(sz);
    v = 32'd0;
    for (int i = 0; i < n; i++) begin
      k = int'(a % 4) + i;
      b = (a >= MMIO) ? ioval[8*k +: 8] : bmem[int'(a % 4096) + i];
      v = v | (32'(b) << (8 * i));
    end
    if (!sg && n == 1 && v[7]) v = v | 32'hFFFF_FF00;
    if (!sg && n == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < nbytes(sz); i++) bmem[int'(a % 4096) + i] = d[8*i +: 8];
  endtask

  task automatic xfer(input bit use3, input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input logic sg, output logic [31:0] dout,
                      output logic err, output int edges, output int busy_n, output int wr_n,
                      output int rd_n);
    we2 = we; addr2 = a; din2 = d; size2 = sz; sign2 = sg;
    if (use3) req3 = 1'b1;
    else req0 = 1'b1;
    busy_n = 0; wr_n = 0; rd_n = 0;
    step();
    req0 = 1'b0; req3 = 1'b0;
    edges = 1;
    while (!(use3 ? done_3 : done_0) && edges < 40) begin
      busy_n += int'(use3 ? busy_3 : busy_0);
      wr_n   += int'(use3 ? iowr_3 : iowr_0);
      rd_n   += int'(use3 ? iord_3 : iord_0);
      step();
      edges++;
    end
    dout = use3 ? dout2_3 : dout2_0;
    err  = use3 ? err_3 : err_0;
  endtask

  // Port-2 operation on the zero-wait instance, checked against the model.
  task automatic op0(input string tag, input logic we, input logic [31:0] a,
                     input logic [31:0] d, input logic [1:0] sz, input logic sg);
    logic [31:0] dout, exp_d;
    logic err, e_err;
    int edges, bn, wn, rn;
    e_err = exp_err(sz, a);
    exp_d = (e_err || we) ? 32'd0 : exp_load(sz, sg, a, io_in);
    xfer(1'b0, we, a, d, sz, sg, dout, err, edges, bn, wn, rn);
    chk({tag, "_lat"}, 32'(edges), 32'd2);
    chk({tag, "_err"}, 32'(err), 32'(e_err));
    if (!we) chk({tag, "_dout"}, dout, exp_d);
    chk({tag, "_iowr"}, 32'(wn), 32'((a >= MMIO && we && !e_err) ? 1 : 0));
    if (we && !e_err && a < MMIO) model_store(sz, a, d);
  endtask

  logic [31:0] r_dout, r_addr, r_din;
  logic        r_err, r_we;
  logic [1:0]  r_sz;
  int r_edges, r_busy, r_wr, r_rd, cnt;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rden1 = 1'b0; addr1 = '0; req0 = 1'b0; req3 = 1'b0; we2 = 1'b0;
    addr2 = '0; din2 = '0; size2 = 2'd2; sign2 = 1'b0; io_in = '0;
    repeat (3) step();
    chk("rst_dout1", dout1_0, 32'd0);
    chk("rst_flags", {28'd0, busy_0, done_0, err_0, iowr_0 | iord_0}, 32'd0);
    chk("rst_dout2", dout2_0, 32'd0);
    chk("rst_ioaddr", ioaddr_0 | iodout_0, 32'd0);
    chk("rst_flags3", {30'd0, busy_3, done_3}, 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 64; i++) begin
      r_din = $urandom;
      xfer(1'b0, 1'b1, 32'(4 * i), r_din, 2'd2, 1'b0, r_dout, r_err, r_edges, r_busy, r_wr, r_rd);
      model_store(2'd2, 32'(4 * i), r_din);
    end

    op0("sw100", 1'b1, 32'h100, 32'hDEAD_BEEF, 2'd2, 1'b0);
    op0("lw100", 1'b0, 32'h100, 32'h0, 2'd2, 1'b0);
    chk("lw100_const", dout2_0, 32'hDEAD_BEEF);
    op0("sb101", 1'b1, 32'h101, 32'h80, 2'd0, 1'b0);
    op0("lb101", 1'b0, 32'h101, 32'h0, 2'd0, 1'b0);
    chk("lb101_const", dout2_0, 32'hFFFF_FF80);
    op0("lbu101", 1'b0, 32'h101, 32'h0, 2'd0, 1'b1);
    chk("lbu101_const", dout2_0, 32'h0000_0080);
    op0("lw102", 1'b0, 32'h102, 32'h0, 2'd2, 1'b0);
    chk("lw102_err", {31'd0, err_0}, 32'd1);
    op0("sh103", 1'b1, 32'h103, 32'hFFFF, 2'd1, 1'b0);
    op0("lw100b", 1'b0, 32'h100, 32'h0, 2'd2, 1'b0);
    chk("word100", dout2_0, 32'hDEAD_80EF);
    step();
    chk("dout2_hold", dout2_0, 32'hDEAD_80EF);
    chk("done_pulse", {31'd0, done_0}, 32'd0);

    xfer(1'b0, 1'b1, 32'h1100_0000, 32'h55, 2'd2, 1'b0, r_dout, r_err, r_edges, r_busy, r_wr,
         r_rd);
    chk("io_wr_pulses", 32'(r_wr), 32'd1);
    chk("io_addr", ioaddr_0, 32'h1100_0000);
    chk("io_dout", iodout_0, 32'h55);
    io_in = 32'h1234;
    xfer(1'b0, 1'b0, 32'h1100_0000, 32'h0, 2'd2, 1'b0, r_dout, r_err, r_edges, r_busy, r_wr,
         r_rd);
    chk("io_rd_pulses", 32'(r_rd), 32'd1);
    chk("io_load", r_dout, 32'h1234);
    op0("oor", 1'b0, 32'h2000, 32'h0, 2'd2, 1'b0);
    op0("size3", 1'b1, 32'h104, 32'h0, 2'd3, 1'b0);

    op0("sw104", 1'b1, 32'h104, 32'h0BAD_F00D, 2'd2, 1'b0);
    rden1 = 1'b1; addr1 = 10'h040;
    step();
    chk("p1_read", dout1_0, 32'hDEAD_80EF);
    addr1 = 10'h041;
    step();
    we2 = 1'b1; addr2 = 32'h104; din2 = 32'hCAFE_F00D; size2 = 2'd2; req0 = 1'b1;
    step();
    req0 = 1'b0;
    step();
    chk("collide_old", dout1_0, 32'h0BAD_F00D);
    step();
    chk("collide_new", dout1_0, 32'hCAFE_F00D);
    model_store(2'd2, 32'h104, 32'hCAFE_F00D);
    rden1 = 1'b0; addr1 = 10'h040;
    step();
    chk("p1_hold", dout1_0, 32'hCAFE_F00D);

    for (int n = 0; n < 120; n++) begin
      cnt = int'($urandom_range(0, 9));
      r_we = 1'($urandom_range(0, 1));
      r_sz = 2'($urandom_range(0, 2));
      r_addr = 32'($urandom_range(0, 255));
      if (cnt == 0) r_sz = 2'd3;
      if (cnt == 1) r_addr = MMIO + 32'($urandom_range(0, 255));
      if (cnt == 2) r_addr = MEMB + 32'($urandom_range(0, 4095));
      io_in = $urandom;
      op0("rnd", r_we, r_addr, $urandom, r_sz, 1'($urandom_range(0, 1)));
    end

    xfer(1'b1, 1'b1, 32'h200, 32'h1111_2222, 2'd2, 1'b0, r_dout, r_err, r_edges, r_busy, r_wr,
         r_rd);
    chk("ws3_lat", 32'(r_edges), 32'(2 + WS3));
    chk("ws3_busy", 32'(r_busy), 32'(1 + WS3));
    xfer(1'b1, 1'b0, 32'h200, 32'h0, 2'd2, 1'b0, r_dout, r_err, r_edges, r_busy, r_wr, r_rd);
    chk("ws3_load", r_dout, 32'h1111_2222);
    chk("ws3_load_lat", 32'(r_edges), 32'(2 + WS3));
    step();

    we2 = 1'b0; addr2 = 32'h200; size2 = 2'd2; sign2 = 1'b0; req3 = 1'b1;
    step();
    req3 = 1'b0;
    step();
    we2 = 1'b1; din2 = 32'h9999_9999; req3 = 1'b1;
    step();
    req3 = 1'b0; we2 = 1'b0;
    step();
    req3 = 1'b1;
    step();
    chk("mid_done", {31'd0, done_3}, 32'd1);
    chk("mid_dout", dout2_3, 32'h1111_2222);
    step();
    req3 = 1'b0;
    cnt = 1;
    while (!done_3 && cnt < 40) begin
      step();
      cnt++;
    end
    chk("b2b_lat", 32'(cnt), 32'(2 + WS3));
    chk("b2b_dout", dout2_3, 32'h1111_2222);
    chk("b2b_we", {31'd0, iowr_3}, 32'd0);
    step();

    we2 = 1'b1; addr2 = 32'h200; din2 = 32'hAAAA_AAAA; req3 = 1'b1;
    step();
    req3 = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_flags", {29'd0, busy_3, done_3, iowr_3}, 32'd0);
    chk("rst_mid_io", ioaddr_3 | iodout_3 | dout2_3, 32'd0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 2) rst_n = 1'b1;
      cnt += int'(done_3);
    end
    chk("rst_no_done", 32'(cnt), 32'd0);
    rden1 = 1'b1; addr1 = 10'h080;
    step();
    chk("rst_mem_kept", dout1_3, 32'h1111_2222);
    addr1 = 10'h040;
    step();
    chk("rst_mem_kept0", dout1_0, 32'hDEAD_80EF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
